// File: rtl/bp_stall_counter_drain.sv
// Stall-reason performance counters with snapshot-and-drain readout over a valid/ready stream.
// Optional macro BP_STALL_CNT_SATURATE_EN: live counters saturate instead of wrapping.
module bp_stall_counter_drain #(
  parameter int num_reasons_p = 21,
  parameter int cnt_width_p   = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   freeze_i,
  input  logic                   commit_v_i,
  input  logic                   stall_v_i,
  input  logic [4:0]             stall_reason_i,
  input  logic                   dump_i,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [4:0]             idx_o,
  output logic [cnt_width_p-1:0] count_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int n_cnt_c = num_reasons_p + 1;
  localparam logic [4:0] last_idx_c = 5'(num_reasons_p);
  localparam logic [cnt_width_p-1:0] one_c = cnt_width_p'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_r, state_s;
  logic [4:0] ptr_r, ptr_s;
  logic [cnt_width_p-1:0] live_r [n_cnt_c];
  logic [cnt_width_p-1:0] snap_r [n_cnt_c];
  logic [n_cnt_c-1:0] hit_s;
  logic count_en_s;
  logic dump_take_s;
  logic v_s, busy_s, done_s;
  logic [4:0] idx_s;
  logic [cnt_width_p-1:0] count_s;

  function automatic logic [cnt_width_p-1:0] bump(input logic [cnt_width_p-1:0] v);
`ifdef BP_STALL_CNT_SATURATE_EN
    bump = (v == {cnt_width_p{1'b1}}) ? v : v + one_c;
`else
    bump = v + one_c;
`endif
  endfunction

  // One-hot increment target; out-of-range reasons match no counter.
  always_comb begin
    count_en_s = !reset_i && !freeze_i && !commit_v_i;
    hit_s = '0;
    for (int i = 0; i < num_reasons_p; i++) begin
      if (count_en_s && stall_v_i && (stall_reason_i == 5'(i))) begin
        hit_s[i] = 1'b1;
      end else begin
        hit_s[i] = 1'b0;
      end
    end
    if (count_en_s && !stall_v_i) begin
      hit_s[num_reasons_p] = 1'b1;
    end else begin
      hit_s[num_reasons_p] = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    dump_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (dump_i) begin
          dump_take_s = 1'b1;
          state_s     = DRAIN;
          ptr_s       = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (ready_i) begin
          ptr_s = ptr_r + 5'd1;
          if (ptr_r == last_idx_c) begin
            state_s = DONE;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
        ptr_s   = 5'd0;
      end
      default: begin
        state_s = IDLE;
        ptr_s   = 5'd0;
      end
    endcase

    v_s    = (state_s == DRAIN);
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
    idx_s  = v_s ? ptr_s : 5'd0;
    // The snapshot is loaded on the same edge that enters DRAIN, so entry 0 comes from the live copy.
    if (!v_s) begin
      count_s = '0;
    end else if (dump_take_s) begin
      count_s = live_r[0];
    end else begin
      count_s = snap_r[ptr_s];
    end
  end

  // FSM state, pointer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= 5'd0;
      v_o     <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      idx_o   <= 5'd0;
      count_o <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      v_o     <= v_s;
      busy_o  <= busy_s;
      done_o  <= done_s;
      idx_o   <= idx_s;
      count_o <= count_s;
    end
  end

  // Live counters and snapshot; a dump clears live counts but keeps this cycle's increment.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < n_cnt_c; i++) begin
      if (reset_i) begin
        live_r[i] <= '0;
        snap_r[i] <= '0;
      end else if (dump_take_s) begin
        snap_r[i] <= live_r[i];
        live_r[i] <= hit_s[i] ? one_c : '0;
      end else if (hit_s[i]) begin
        live_r[i] <= bump(live_r[i]);
      end
    end
  end

endmodule

// File: tb/tb_bp_stall_counter_drain.sv
// Scoreboard bench for bp_stall_counter_drain: a reference counter model feeds expected drain entries.
module tb_bp_stall_counter_drain;

  logic clk = 1'b0;
  logic reset_i, freeze_i, commit_v_i, stall_v_i, dump_i, ready_i;
  logic [4:0] stall_reason_i;
  logic v_o, busy_o, done_o;
  logic [4:0] idx_o;
  logic [31:0] count_o;
  logic v3, busy3, done3;
  logic [4:0] idx3;
  logic [2:0] cnt3;

  int checks = 0;
  int errors = 0;
  int mdl [22];
  logic [4:0]  exp_idx [$];
  logic [31:0] exp_cnt [$];

  bp_stall_counter_drain dut (
    .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .commit_v_i(commit_v_i),
    .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i), .dump_i(dump_i),
    .v_o(v_o), .ready_i(ready_i), .idx_o(idx_o), .count_o(count_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  bp_stall_counter_drain #(.num_reasons_p(21), .cnt_width_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .commit_v_i(commit_v_i),
    .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i), .dump_i(dump_i),
    .v_o(v3), .ready_i(ready_i), .idx_o(idx3), .count_o(cnt3),
    .busy_o(busy3), .done_o(done3)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model applies this cycle's increment first.
  task automatic tick();
    if (reset_i) begin
      for (int i = 0; i < 22; i++) mdl[i] = 0;
    end else if (!freeze_i && !commit_v_i) begin
      if (stall_v_i) begin
        if (stall_reason_i < 5'd21) mdl[stall_reason_i] = mdl[stall_reason_i] + 1;
      end else begin
        mdl[21] = mdl[21] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_dump();
    for (int i = 0; i < 22; i++) begin
      exp_idx.push_back(5'(i));
      exp_cnt.push_back(32'(mdl[i]));
      mdl[i] = 0;
    end
    dump_i = 1'b1;
    tick();
    dump_i = 1'b0;
    checks++;
    if (v_o !== 1'b1 || idx_o !== 5'd0) begin
      errors++;
      $display("FAIL dump_latency: v_o=%b idx_o=%0d, required v_o=1 idx_o=0", v_o, idx_o);
    end
  endtask

  // Drain all entries, comparing each handshake with the scoreboard; optional hold, dump noise, abort.
  task automatic run_drain(input int hold_idx, input int hold_n, input int abort_idx,
                           input bit dump_noise, output int hs);
    int held, cyc;
    bit fin;
    logic [4:0] last_idx;
    logic [31:0] last_cnt, ec;
    logic [4:0] ei;
    hs = 0; held = 0; cyc = 0; fin = 1'b0;
    last_idx = 5'd0; last_cnt = 32'd0;
    while (!fin && cyc < 200) begin
      if (done_o) begin
        fin = 1'b1;
        dump_i = 1'b0;
        ready_i = 1'b0;
        checks++;
        if (cyc != 22 + hold_n) begin
          errors++;
          $display("FAIL done_timing: done at drain cycle %0d, required %0d", cyc, 22 + hold_n);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: done_o=%b busy_o=%b, required 0 0", done_o, busy_o);
        end
      end else begin
        dump_i = dump_noise;
        if (v_o && idx_o == 5'(hold_idx) && held < hold_n) begin
          ready_i = 1'b0;
          if (held > 0) begin
            checks++;
            if (idx_o !== last_idx || count_o !== last_cnt) begin
              errors++;
              $display("FAIL hold_stable: idx=%0d cnt=%0d, required idx=%0d cnt=%0d",
                       idx_o, count_o, last_idx, last_cnt);
            end
          end
          last_idx = idx_o; last_cnt = count_o;
          held++;
        end else begin
          ready_i = 1'b1;
        end
        if (v_o && ready_i) begin
          hs++;
          checks++;
          if (exp_idx.size() == 0) begin
            errors++;
            $display("FAIL entry_extra: idx=%0d cnt=%0d, required no entry", idx_o, count_o);
          end else begin
            ei = exp_idx.pop_front();
            ec = exp_cnt.pop_front();
            if (idx_o !== ei || count_o !== ec) begin
              errors++;
              $display("FAIL entry: idx=%0d cnt=%0d, required idx=%0d cnt=%0d", idx_o, count_o, ei, ec);
            end
          end
          if (int'(idx_o) == abort_idx) begin
            tick();
            ready_i = 1'b0;
            dump_i = 1'b0;
            reset_i = 1'b1;
            tick();
            reset_i = 1'b0;
            checks++;
            if (v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
              errors++;
              $display("FAIL abort: v_o=%b busy_o=%b done_o=%b, required 0 0 0", v_o, busy_o, done_o);
            end
            exp_idx.delete();
            exp_cnt.delete();
            return;
          end
        end
        tick();
        cyc++;
      end
    end
    dump_i = 1'b0;
    ready_i = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL drain_timeout: no done_o within 200 cycles, required done_o");
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || idx_o !== 5'd0 || count_o !== 32'd0) begin
      errors++;
      $display("FAIL reset: v=%b busy=%b done=%b idx=%0d cnt=%0d, required all 0",
               v_o, busy_o, done_o, idx_o, count_o);
    end
    checks++;
    if (v3 !== 1'b0 || cnt3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_w3: v=%b cnt=%0d, required 0 0", v3, cnt3);
    end
  endtask

  task automatic test_count();
    int hs;
    commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd4;
    repeat (5) tick();
    commit_v_i = 1'b1; stall_v_i = 1'b0;
    repeat (3) tick();
    commit_v_i = 1'b0;
    repeat (2) tick();
    commit_v_i = 1'b1;
    do_dump();
    run_drain(-1, 0, -1, 1'b0, hs);
  endtask

  task automatic test_backpressure();
    int hs;
    commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd7;
    repeat (3) tick();
    commit_v_i = 1'b1;
    do_dump();
    run_drain(7, 3, -1, 1'b0, hs);
    checks++;
    if (hs != 22) begin
      errors++;
      $display("FAIL handshakes: got %0d, required 22", hs);
    end
  endtask

  task automatic test_freeze();
    int hs;
    freeze_i = 1'b1; commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd2;
    repeat (10) tick();
    freeze_i = 1'b0; commit_v_i = 1'b1;
    do_dump();
    run_drain(-1, 0, -1, 1'b0, hs);
  endtask

  task automatic test_simultaneous();
    int hs;
    commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd3;
    repeat (2) tick();
    do_dump();
    commit_v_i = 1'b1;
    run_drain(-1, 0, -1, 1'b0, hs);
    commit_v_i = 1'b0; stall_reason_i = 5'd25;
    repeat (2) tick();
    commit_v_i = 1'b1;
    do_dump();
    run_drain(-1, 0, -1, 1'b0, hs);
  endtask

  task automatic test_back_to_back();
    int hs;
    commit_v_i = 1'b0; stall_v_i = 1'b0;
    repeat (4) tick();
    do_dump();
    run_drain(-1, 0, -1, 1'b1, hs);
    do_dump();
    run_drain(-1, 0, -1, 1'b0, hs);
    commit_v_i = 1'b1;
  endtask

  task automatic test_abort();
    int hs;
    commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd10;
    repeat (4) tick();
    commit_v_i = 1'b1;
    do_dump();
    run_drain(-1, 0, 10, 1'b0, hs);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_done: done_o=%b, required 0", done_o);
      end
      tick();
    end
    do_dump();
    run_drain(-1, 0, -1, 1'b0, hs);
  endtask

  task automatic test_width();
    int hs;
    logic [2:0] exp3;
`ifdef BP_STALL_CNT_SATURATE_EN
    exp3 = 3'd7;
`else
    exp3 = 3'd1;
`endif
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    commit_v_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd0;
    repeat (9) tick();
    commit_v_i = 1'b1;
    do_dump();
    checks++;
    if (idx3 !== 5'd0 || cnt3 !== exp3) begin
      errors++;
      $display("FAIL width3: idx=%0d cnt=%0d, required idx=0 cnt=%0d", idx3, cnt3, exp3);
    end
    run_drain(-1, 0, -1, 1'b0, hs);
  endtask

  initial begin
    reset_i = 1'b1; freeze_i = 1'b0; commit_v_i = 1'b1; stall_v_i = 1'b0;
    stall_reason_i = 5'd0; dump_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < 22; i++) mdl[i] = 0;
    test_reset();
    test_count();
    test_backpressure();
    test_freeze();
    test_simultaneous();
    test_back_to_back();
    test_abort();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_stall_counter_drain.md
BP_STALL_COUNTER_DRAIN -- requirements
Module: bp_stall_counter_drain

Interface
REQ-001 The block SHALL have parameter num_reasons_p, default 21, giving the number of stall-reason counters, indexed 0..num_reasons_p-1.
REQ-002 The block SHALL have parameter cnt_width_p, default 32, giving the width of each counter.
REQ-003 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port freeze_i, input, 1 bit: core frozen; suppresses counting.
REQ-006 The block SHALL have the port commit_v_i, input, 1 bit: an instruction committed this cycle.
REQ-007 The block SHALL have the port stall_v_i, input, 1 bit: the stall reason is valid.
REQ-008 The block SHALL have the port stall_reason_i, input, 5 bits: priority-encoded stall reason index.
REQ-009 The block SHALL have the port dump_i, input, 1 bit: request to snapshot and drain all counters.
REQ-010 The block SHALL have the port v_o, output, 1 bit: drain entry valid.
REQ-011 The block SHALL have the port ready_i, input, 1 bit: consumer accepts the entry.
REQ-012 The block SHALL have the port idx_o, output, 5 bits: counter index of the current entry.
REQ-013 The block SHALL have the port count_o, output, cnt_width_p bits: snapshot value of the current entry.
REQ-014 The block SHALL have the port busy_o, output, 1 bit: high in states other than IDLE.
REQ-015 The block SHALL have the port done_o, output, 1 bit: one-cycle pulse at drain completion.

Function
REQ-016 The block SHALL count only cycles where counting is enabled: reset_i=0, freeze_i=0 and commit_v_i=0.
- stall_v_i=1 and stall_reason_i<num_reasons_p: increment live counter[stall_reason_i].
- stall_v_i=1 and stall_reason_i>=num_reasons_p: increment nothing.
- stall_v_i=0: increment the unknown counter at index num_reasons_p.
REQ-017 The block SHALL implement the FSM states IDLE, DRAIN and DONE; the reset state is IDLE.
REQ-018 In IDLE with dump_i=1, the block SHALL, in the same edge:
- copy all num_reasons_p+1 live counters into the snapshot registers;
- clear the live counters, except that this cycle's increment lands in the cleared counter, which becomes 1;
- set the entry pointer to 0 and go to DRAIN.
REQ-019 In DRAIN, the block SHALL drive v_o=1, idx_o=pointer and count_o=snapshot[pointer].
REQ-020 The block SHALL hold idx_o and count_o stable while v_o=1 and ready_i=0.
REQ-021 On a handshake (v_o&ready_i), the block SHALL increment the pointer.
REQ-022 On the handshake with pointer=num_reasons_p, the block SHALL go to DONE, making the drain num_reasons_p+1 entries total.
REQ-023 In DONE, the block SHALL assert done_o=1 for exactly one cycle and then go to IDLE.
REQ-024 When there is no stall on ready_i, minimum latency SHALL be: dump_i at cycle N, first v_o at N+1, done_o at N+num_reasons_p+2.
REQ-025 The block SHALL ignore dump_i in DRAIN and DONE.
REQ-026 The block SHALL continue counting during DRAIN and DONE, independently of the snapshot.
REQ-027 The block SHALL hold v_o=0 in IDLE and DONE.

Reset
REQ-028 Reset SHALL force:
- state=IDLE and pointer=0;
- all live and snapshot counters=0;
- v_o=0, busy_o=0, done_o=0, idx_o=0, count_o=0.
REQ-029 A reset asserted mid-drain SHALL abort the drain with no done_o pulse, and v_o SHALL be 0 on the next cycle.

Configuration
REQ-030 The block SHALL support the macro BP_STALL_CNT_SATURATE_EN.
- Defined: live counters saturate at 2^cnt_width_p-1 and hold there.
- Undefined: live counters wrap modulo 2^cnt_width_p, so all-ones+1 gives 0.

Verification
REQ-031 Counting: 5 cycles with stall_v_i=1 and reason=4, 3 commit cycles, 2 cycles with stall_v_i=0, then dump_i -> entries show idx 4 count 5, idx 21 count 2, all others 0.
REQ-032 Backpressure: during a drain, hold ready_i=0 for 3 cycles on entry idx 7 -> idx_o and count_o are stable for those cycles, and exactly 22 handshakes occur in total.
REQ-033 Freeze: with freeze_i=1 for 10 cycles while stall_v_i=1 and reason=2, then dump_i -> idx 2 count is 0.
REQ-034 Simultaneous events: dump_i coincides with a reason=3 stall -> the snapshot excludes that cycle, the live counter[3] becomes 1, and a second dump shows idx 3 count 1.
REQ-035 Reset mid-drain: assert reset_i after the handshake of idx 10 -> v_o=0 next cycle, done_o is never pulsed, and a following dump shows all counts 0.
REQ-036 Width: with cnt_width_p=3 and 9 stalls of reason 0 -> count 7 with BP_STALL_CNT_SATURATE_EN defined, count 1 without.
